// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file controller slice.
package rf_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Register 0 is hardwired: never written, cleared or dumped.
  localparam int R0_ADDR = 0;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    DUMP_RD,
    DUMP_HOLD,
    DUMP_END
  } state_t;

endpackage

// File: rtl/rf_ctrl_mux.sv
// Combinational port mux: picks pipeline, debug channel or controller as the
// driver of the register-file ports, based on the controller state and index.
import rf_ctrl_pkg::*;

module rf_ctrl_mux #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  state_t            state,
  input  logic [ADDR_W-1:0] idx,
  input  logic [ADDR_W-1:0] cpu_p0_addr,
  input  logic [ADDR_W-1:0] cpu_p1_addr,
  input  logic              cpu_re0,
  input  logic              cpu_re1,
  input  logic [ADDR_W-1:0] cpu_dst_addr,
  input  logic [DATA_W-1:0] cpu_dst,
  input  logic              cpu_we,
  input  logic              dbg_wr_valid,
  input  logic [ADDR_W-1:0] dbg_wr_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  input  logic              dbg_dump_req,
  output logic              dbg_wr_ready,
  output logic [ADDR_W-1:0] rf_p0_addr,
  output logic [ADDR_W-1:0] rf_p1_addr,
  output logic              rf_re0,
  output logic              rf_re1,
  output logic [ADDR_W-1:0] rf_dst_addr,
  output logic [DATA_W-1:0] rf_dst,
  output logic              rf_we
);

  // Select the RF port drivers; the debug write only fills idle IDLE write slots.
  always_comb begin
    dbg_wr_ready = 1'b0;
    rf_p0_addr   = '0;
    rf_p1_addr   = '0;
    rf_re0       = 1'b0;
    rf_re1       = 1'b0;
    rf_dst_addr  = '0;
    rf_dst       = '0;
    rf_we        = 1'b0;
    case (state)
      CLEAR: begin
        rf_we       = 1'b1;
        rf_dst_addr = idx;
      end
      IDLE, DUMP_END: begin
        rf_p0_addr  = cpu_p0_addr;
        rf_p1_addr  = cpu_p1_addr;
        rf_re0      = cpu_re0;
        rf_re1      = cpu_re1;
        rf_dst_addr = cpu_dst_addr;
        rf_dst      = cpu_dst;
        rf_we       = cpu_we;
        if (state == IDLE && !cpu_we && dbg_wr_valid && !dbg_dump_req) begin
          dbg_wr_ready = 1'b1;
          rf_dst_addr  = dbg_wr_addr;
          rf_dst       = dbg_wr_data;
          rf_we        = (dbg_wr_addr != ADDR_W'(R0_ADDR));
        end
      end
      DUMP_RD: begin
        rf_p0_addr  = idx;
        rf_re0      = 1'b1;
        rf_dst_addr = idx;
      end
      DUMP_HOLD: begin
        rf_p0_addr  = idx;
        rf_dst_addr = idx;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rf_ctrl.sv
// Register-file sequencer/arbiter: clears R1..R15 after reset, passes the
// pipeline through, merges debug writes and streams a debug dump of R1..R15.
import rf_ctrl_pkg::*;

module rf_ctrl #(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_p0_addr,
  input  logic [ADDR_W-1:0] cpu_p1_addr,
  input  logic              cpu_re0,
  input  logic              cpu_re1,
  input  logic [ADDR_W-1:0] cpu_dst_addr,
  input  logic [DATA_W-1:0] cpu_dst,
  input  logic              cpu_we,
  output logic              stall,
  input  logic              dbg_wr_valid,
  input  logic [ADDR_W-1:0] dbg_wr_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  output logic              dbg_wr_ready,
  input  logic              dbg_dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic [ADDR_W-1:0] rf_p0_addr,
  output logic [ADDR_W-1:0] rf_p1_addr,
  output logic              rf_re0,
  output logic              rf_re1,
  output logic [ADDR_W-1:0] rf_dst_addr,
  output logic [DATA_W-1:0] rf_dst,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_p0
);

  // Highest register index; the clear and dump both stop here, so idx never wraps.
  localparam logic [ADDR_W-1:0] LAST_IDX    = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] FIRST_IDX   = ADDR_W'(1);
  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] idx;
  logic              beat_taken;

  assign beat_taken = dump_valid && dump_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= next_state;
  end

  // Next-state, stall and done decode.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    dump_done  = 1'b0;
    case (state)
      CLEAR: begin
        stall = 1'b1;
        if (idx == LAST_IDX) next_state = IDLE;
      end
      IDLE: begin
        if (dbg_dump_req) begin
          stall      = 1'b1;
          next_state = DUMP_RD;
        end
      end
      DUMP_RD: begin
        stall      = 1'b1;
        next_state = DUMP_HOLD;
      end
      DUMP_HOLD: begin
        stall = 1'b1;
        if (beat_taken) next_state = (idx == LAST_IDX) ? DUMP_END : DUMP_RD;
      end
      DUMP_END: begin
        dump_done  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = RESET_STATE;
    endcase
  end

  // Index counter and dump beat registers; RF read data is valid by the posedge after DUMP_RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= FIRST_IDX;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        CLEAR: idx <= (idx == LAST_IDX) ? FIRST_IDX : idx + 1'b1;
        DUMP_RD: begin
          dump_data  <= rf_p0;
          dump_idx   <= idx;
          dump_valid <= 1'b1;
        end
        DUMP_HOLD: begin
          if (beat_taken) begin
            dump_valid <= 1'b0;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        DUMP_END: idx <= FIRST_IDX;
        default: ;
      endcase
    end
  end

  rf_ctrl_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mux (
    .state        (state),
    .idx          (idx),
    .cpu_p0_addr  (cpu_p0_addr),
    .cpu_p1_addr  (cpu_p1_addr),
    .cpu_re0      (cpu_re0),
    .cpu_re1      (cpu_re1),
    .cpu_dst_addr (cpu_dst_addr),
    .cpu_dst      (cpu_dst),
    .cpu_we       (cpu_we),
    .dbg_wr_valid (dbg_wr_valid),
    .dbg_wr_addr  (dbg_wr_addr),
    .dbg_wr_data  (dbg_wr_data),
    .dbg_dump_req (dbg_dump_req),
    .dbg_wr_ready (dbg_wr_ready),
    .rf_p0_addr   (rf_p0_addr),
    .rf_p1_addr   (rf_p1_addr),
    .rf_re0       (rf_re0),
    .rf_re1       (rf_re1),
    .rf_dst_addr  (rf_dst_addr),
    .rf_dst       (rf_dst),
    .rf_we        (rf_we)
  );

endmodule
